// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, FSM states and error codes for the calc blocks.
// No ports; imported by calc_div_unit and calc_inverse.
package calc_pkg;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

    localparam int A_DWIDTH = 32;
    localparam int B_DWIDTH = 32;
    localparam int C_DWIDTH = 32;
    localparam int D_DWIDTH = 32;

    localparam int Q_DWIDTH = max3(A_DWIDTH + C_DWIDTH,
                                   B_DWIDTH + C_DWIDTH,
                                   D_DWIDTH) + 4;

    // Division width; also the number of iterations per pass.
    localparam int NW = Q_DWIDTH + 1;

    // Width of the divider iteration counter.
    localparam int CW = $clog2(NW + 1);

    localparam logic signed [NW-1:0] NW_ONE   = NW'(1);
    localparam logic signed [NW-1:0] NW_THREE = NW'(3);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV1,
        MID,
        DIV2,
        DONE
    } calc_inv_state_t;

    localparam logic [1:0] CALC_ERR_OK      = 2'b00;
    localparam logic [1:0] CALC_ERR_DIV0    = 2'b01;
    localparam logic [1:0] CALC_ERR_INEXACT = 2'b10;
    localparam logic [1:0] CALC_ERR_RANGE   = 2'b11;

endpackage

// File: rtl/calc_div_unit.sv
// calc_div_unit: NW-bit signed restoring divider, one quotient bit per
// cycle, MSB first. Quotient truncates toward zero; remainder takes the
// sign of the dividend.
// Ports: i_clk, i_rst (async, active-high), i_start, i_dividend,
//        i_divisor in; o_busy, o_done (1-cycle pulse), o_quotient,
//        o_remainder out. Results are stable from o_done until next start.
module calc_div_unit
    import calc_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic signed [NW-1:0] i_dividend,
    input  logic signed [NW-1:0] i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic signed [NW-1:0] o_quotient,
    output logic signed [NW-1:0] o_remainder
);

    logic [NW-1:0] r_rem;
    logic [NW-1:0] r_quo;
    logic [NW-1:0] r_div;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    logic [NW-1:0] w_dvd_mag;
    logic [NW-1:0] w_div_mag;
    logic [NW-1:0] w_rem_in;
    logic [NW-1:0] w_quo_in;
    logic [NW-1:0] w_div_in;
    logic [NW:0]   w_shift;
    logic [NW:0]   w_trial;
    logic [NW-1:0] w_rem_nx;
    logic [NW-1:0] w_quo_nx;

    assign w_dvd_mag = i_dividend[NW-1] ? $unsigned(-i_dividend)
                                        : $unsigned(i_dividend);
    assign w_div_mag = i_divisor[NW-1]  ? $unsigned(-i_divisor)
                                        : $unsigned(i_divisor);

    // The start cycle already performs the first iteration on the fresh
    // operands, so a pass occupies exactly NW cycles including start.
    always_comb begin
        w_rem_in = i_start ? '0        : r_rem;
        w_quo_in = i_start ? w_dvd_mag : r_quo;
        w_div_in = i_start ? w_div_mag : r_div;
        w_shift  = {w_rem_in, w_quo_in[NW-1]};
        w_trial  = w_shift - {1'b0, w_div_in};
        if (!w_trial[NW]) begin
            w_rem_nx = w_trial[NW-1:0];
            w_quo_nx = {w_quo_in[NW-2:0], 1'b1};
        end else begin
            w_rem_nx = w_shift[NW-1:0];
            w_quo_nx = {w_quo_in[NW-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (i_start) begin
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_div   <= w_div_mag;
            r_neg_q <= i_dividend[NW-1] ^ i_divisor[NW-1];
            r_neg_r <= i_dividend[NW-1];
            r_cnt   <= CW'(NW - 1);
            r_done  <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_cnt   <= r_cnt - 1'b1;
            r_done  <= (r_cnt == CW'(1));
        end else begin
            r_done  <= 1'b0;
        end
    end

    assign o_busy      = (r_cnt != '0);
    assign o_done      = r_done;
    assign o_quotient  = r_neg_q ? -$signed(r_quo) : $signed(r_quo);
    assign o_remainder = r_neg_r ? -$signed(r_rem) : $signed(r_rem);

endmodule

// File: rtl/calc_inverse.sv
// calc_inverse: recovers c from a, b, d and Q = (a-b)(1+3c) - 4d using
// one shared divider twice: t = (Q+4d)/(a-b), then c = (t-1)/3.
// Ports: clk_i, rst_i (async, active-high); valid_i/ready_o accept side
//        with a_i, b_i, d_i, q_i; valid_o/ready_i result side with c_o,
//        err_o. Macro CALC_INVERSE_ERR_EN enables err_o reporting,
//        otherwise err_o is tied to 2'b00.
module calc_inverse
    import calc_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic signed [A_DWIDTH-1:0] a_i,
    input  logic signed [B_DWIDTH-1:0] b_i,
    input  logic signed [D_DWIDTH-1:0] d_i,
    input  logic signed [Q_DWIDTH-1:0] q_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic signed [C_DWIDTH-1:0] c_o,
    output logic [1:0]                 err_o
);

    calc_inv_state_t r_state;
    calc_inv_state_t w_state_nx;

    logic signed [A_DWIDTH-1:0] r_a;
    logic signed [B_DWIDTH-1:0] r_b;
    logic signed [D_DWIDTH-1:0] r_d;
    logic signed [Q_DWIDTH-1:0] r_q;
    logic signed [C_DWIDTH-1:0] r_c;
    logic                       r_div0;

    logic                 w_accept;
    logic signed [NW-1:0] w_n;
    logic signed [NW-1:0] w_dd;
    logic                 w_dd_zero;
    logic signed [NW-1:0] w_u;
    logic                 w_start;
    logic signed [NW-1:0] w_dividend;
    logic signed [NW-1:0] w_divisor;
    logic                 w_busy;
    logic                 w_done;
    logic signed [NW-1:0] w_quo;
    logic signed [NW-1:0] w_rem;

    assign w_accept = valid_i & ready_o;

    // Everything is widened to NW bits first, so neither q+4d nor a-b
    // can overflow.
    assign w_n = {{(NW-Q_DWIDTH){r_q[Q_DWIDTH-1]}}, r_q}
               + {{(NW-D_DWIDTH-2){r_d[D_DWIDTH-1]}}, r_d, 2'b00};
    assign w_dd = {{(NW-A_DWIDTH){r_a[A_DWIDTH-1]}}, r_a}
                - {{(NW-B_DWIDTH){r_b[B_DWIDTH-1]}}, r_b};
    assign w_dd_zero = (w_dd == '0);

    // First-pass quotient is held by the divider through MID.
    assign w_u = w_quo - NW_ONE;

    assign w_start = !w_busy &&
                     (((r_state == PREP) && !w_dd_zero) ||
                      ((r_state == MID)  && !r_div0));
    assign w_dividend = (r_state == MID) ? w_u      : w_n;
    assign w_divisor  = (r_state == MID) ? NW_THREE : w_dd;

    calc_div_unit u_div (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_start     (w_start),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Divide-by-zero passes through MID without starting a pass,
    // giving its two-cycle turnaround.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nx = PREP;
            PREP: w_state_nx = w_dd_zero ? MID : DIV1;
            DIV1: if (w_done) w_state_nx = MID;
            MID:  w_state_nx = r_div0 ? DONE : DIV2;
            DIV2: if (w_done) w_state_nx = DONE;
            DONE: if (ready_i) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_q     <= '0;
            r_c     <= '0;
            r_div0  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_a    <= a_i;
                r_b    <= b_i;
                r_d    <= d_i;
                r_q    <= q_i;
                r_c    <= '0;
                r_div0 <= 1'b0;
            end
            if (r_state == PREP) begin
                r_div0 <= w_dd_zero;
            end
            if ((r_state == DIV2) && w_done) begin
                r_c <= w_quo[C_DWIDTH-1:0];
            end
        end
    end

`ifdef CALC_INVERSE_ERR_EN
    logic [1:0] r_err;
    logic       w_c_fits;

    // c fits when all bits from the C sign bit upward agree.
    assign w_c_fits = (&w_quo[NW-1:C_DWIDTH-1]) |
                      (~|w_quo[NW-1:C_DWIDTH-1]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= CALC_ERR_OK;
        end else if (w_accept) begin
            r_err <= CALC_ERR_OK;
        end else if ((r_state == PREP) && w_dd_zero) begin
            r_err <= CALC_ERR_DIV0;
        end else if ((r_state == MID) && !r_div0 && (w_rem != '0)) begin
            r_err <= CALC_ERR_INEXACT;
        end else if ((r_state == DIV2) && w_done &&
                     (r_err == CALC_ERR_OK)) begin
            if (w_rem != '0) begin
                r_err <= CALC_ERR_INEXACT;
            end else if (!w_c_fits) begin
                r_err <= CALC_ERR_RANGE;
            end
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_rem;
    assign w_unused_rem = ^w_rem;
    assign err_o        = CALC_ERR_OK;
`endif

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);
    assign c_o     = r_c;

endmodule

// File: tb/tb_calc_inverse.sv
// tb_calc_inverse: random and directed stimulus for calc_inverse, checked
// every cycle against a wide-integer arithmetic model of the inverse.
module tb_calc_inverse;

    localparam int LAT_DIV  = 140;
    localparam int LAT_DIV0 = 2;
    localparam logic signed [127:0] CMAX = 128'sd2147483647;
    localparam logic signed [127:0] CMIN = -128'sd2147483648;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               valid_i;
    logic               ready_o;
    logic signed [31:0] a_i;
    logic signed [31:0] b_i;
    logic signed [31:0] d_i;
    logic signed [67:0] q_i;
    logic               valid_o;
    logic               ready_i;
    logic signed [31:0] c_o;
    logic [1:0]         err_o;

    calc_inverse dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .d_i     (d_i),
        .q_i     (q_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic signed [31:0] c;
        logic [1:0]         e;
        int                 lat;
        int                 acc;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   hold_ready = 1'b0;
    bit   seen_valid = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: plain wide signed arithmetic, truncating division.
    function automatic void model(input logic signed [31:0] a, b, d,
                                  input logic signed [67:0] q,
                                  output logic signed [31:0] c,
                                  output logic [1:0] e,
                                  output int lat);
        logic signed [127:0] wa, wb, wd, n, dd, t, r1, u, cw, r2;
        wa = a;
        wb = b;
        wd = d;
        n  = q;
        n  = n + 4 * wd;
        dd = wa - wb;
        if (dd == 0) begin
            c   = '0;
            e   = 2'b01;
            lat = LAT_DIV0;
        end else begin
            t   = n / dd;
            r1  = n % dd;
            u   = t - 1;
            cw  = u / 3;
            r2  = u % 3;
            c   = cw[31:0];
            lat = LAT_DIV;
            if (r1 != 0 || r2 != 0) e = 2'b10;
            else if (cw > CMAX || cw < CMIN) e = 2'b11;
            else e = 2'b00;
        end
    endfunction

    function automatic logic signed [67:0] calc_q(
        input logic signed [31:0] a, b, c, d);
        logic signed [127:0] wa, wb, wc, wd, p;
        wa = a;
        wb = b;
        wc = c;
        wd = d;
        p  = (wa - wb) * (1 + 3 * wc) - 4 * wd;
        return p[67:0];
    endfunction

    // Compare process: ready_o every cycle, outputs while valid_o.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                seen_valid = 1'b0;
                continue;
            end
            chk("ready_o", ready_o, q_exp.size() == 0);
            if (valid_o) begin
                if (q_exp.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_valid: got valid_o=1, want 0");
                end else begin
                    if (!seen_valid) begin
                        chk("latency", cyc - q_exp[0].acc, q_exp[0].lat);
                        seen_valid = 1'b1;
                    end
                    chk("c_o", c_o, q_exp[0].c);
                    chk("err_o", err_o, q_exp[0].e);
                    if (ready_i) begin
                        void'(q_exp.pop_front());
                        seen_valid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_op(input logic signed [31:0] a, b, d,
                         input logic signed [67:0] q);
        exp_t e;
        int   w;
        model(a, b, d, q, e.c, e.e, e.lat);
`ifndef CALC_INVERSE_ERR_EN
        e.e = 2'b00;
`endif
        a_i = a;
        b_i = b;
        d_i = d;
        q_i = q;
        valid_i = 1'b1;
        w = 0;
        @(negedge clk_i);
        while (!ready_o && w < 1000) begin
            @(negedge clk_i);
            w++;
        end
        if (!ready_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got ready_o=0, want 1");
            valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        e.acc = cyc;
        q_exp.push_back(e);
        #1;
        valid_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        d_i = $urandom;
        q_i = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q_exp.size() != 0 && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        if (q_exp.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got %0d pending, want 0",
                     q_exp.size());
            q_exp.delete();
        end
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] mc, ra, rb, rc, rd;
        logic [1:0]         me;
        int                 ml, n;
        logic signed [67:0] rq;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        a_i = '0;
        b_i = '0;
        d_i = '0;
        q_i = '0;

        model(10, 4, 3, 84, mc, me, ml);
        chk("model1_c", mc, 5);
        chk("model1_e", me, 2'b00);
        chk("model1_lat", ml, 140);
        model(1, 5, 7, -8, mc, me, ml);
        chk("model2_c", mc, -2);
        chk("model2_e", me, 2'b00);
        model(10, 4, 0, 7, mc, me, ml);
        chk("model3_e", me, 2'b10);
        model(10, 4, 0, 12, mc, me, ml);
        chk("model4_c", mc, 0);
        chk("model4_e", me, 2'b10);
        model(9, 9, 3, 55, mc, me, ml);
        chk("model5_c", mc, 0);
        chk("model5_e", me, 2'b01);
        chk("model5_lat", ml, 2);

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready_o", ready_o, 1);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_c_o", c_o, 0);
        chk("rst_err_o", err_o, 0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;

        do_op(10, 4, 3, 84);
        do_op(1, 5, 7, -8);
        do_op(10, 4, 0, 7);
        do_op(10, 4, 0, 12);
        do_op(9, 9, 123, 456);
        do_op(-7, -7, -1, -1);
        wait_idle();

        hold_ready = 1'b1;
        do_op(-20, 7, 5, calc_q(-20, 7, -99, 5));
        n = 0;
        while (!valid_o && n < 400) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        chk("hold_valid_seen", valid_o, 1);
        repeat (20) @(posedge clk_i);
        #2;
        hold_ready = 1'b0;
        wait_idle();

        do_op(1000, 3, -44, calc_q(1000, 3, 77, -44));
        repeat (50) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        q_exp.delete();
        #1;
        chk("midrst_valid_o", valid_o, 0);
        chk("midrst_c_o", c_o, 0);
        chk("midrst_err_o", err_o, 0);
        chk("midrst_ready_o", ready_o, 1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        do_op(-3, 12, 8, calc_q(-3, 12, -31, 8));
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            rd = $urandom;
            if (i % 3 == 0) begin
                rb = ra + 32'($urandom_range(1, 9));
                rc = 32'($urandom_range(0, 200)) - 100;
            end
            if (ra == rb) rb = ra + 1;
            rq = calc_q(ra, rb, rc, rd);
            model(ra, rb, rd, rq, mc, me, ml);
            chk("golden_c", mc, rc);
            chk("golden_e", me, 2'b00);
            do_op(ra, rb, rd, rq);
        end

        for (int i = 0; i < 15; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            rd = $urandom;
            rq = {$urandom, $urandom, $urandom};
            if (i % 2 == 0) rq = calc_q(ra, rb, $urandom, rd) + 68'sd1;
            do_op(ra, rb, rd, rq);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
